bp_fe_queue_replay_fifo: RTL and testbench



---
 rtl/bp_fe_queue_replay_fifo.sv | 135 +++++++++++++
 tb/tb_bp_fe_queue_replay_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_queue_replay_fifo.sv
// Replayable FIFO between the FE fetch stage and the BE issue stage.
// Three pointers (write, speculative read, commit) let the BE read ahead,
// retire in order (deq), rewind to the oldest unretired entry (roll) or
// flush everything (clr). Priority per cycle: clr > roll > {yumi, deq, enq}.
// Optional feature: define BP_FE_QUEUE_REPLAY_BYPASS_EN to forward data_i to
// data_o in the same cycle when the queue holds no unread entry.
module bp_fe_queue_replay_fifo #(
   parameter int unsigned width_p = 1,
   parameter int unsigned els_p   = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_i,

   input  logic                     clr_v_i,
   input  logic                     deq_v_i,
   input  logic                     roll_v_i,

   input  logic [width_p-1:0]       data_i,
   input  logic                     v_i,
   output logic                     ready_o,

   output logic [width_p-1:0]       data_o,
   output logic                     v_o,
   input  logic                     yumi_i,

   output logic [$clog2(els_p):0]   unretired_cnt_o
);

   localparam int unsigned addr_width_lp = $clog2(els_p);
   localparam int unsigned ptr_width_lp  = addr_width_lp + 1;

   typedef logic [ptr_width_lp-1:0] ptr_t;

   logic [width_p-1:0] mem_q [els_p];

   ptr_t wptr_q, wptr_d;
   ptr_t rptr_q, rptr_d;
   ptr_t cptr_q, cptr_d;

   logic full;
   logic enq_v;
   logic deq_ok;
   logic unread_v;

   logic [addr_width_lp-1:0] waddr;
   logic [addr_width_lp-1:0] raddr;

   assign waddr = wptr_q[addr_width_lp-1:0];
   assign raddr = rptr_q[addr_width_lp-1:0];

   // Full is judged against the commit pointer: unretired entries still own
   // their slots because a roll may replay them.
   assign full = (wptr_q[addr_width_lp-1:0] == cptr_q[addr_width_lp-1:0])
               & (wptr_q[addr_width_lp] != cptr_q[addr_width_lp]);

   assign ready_o  = ~full;
   assign unread_v = (rptr_q != wptr_q);

   // A clr drops any same-cycle write.
   assign enq_v  = v_i & ready_o & ~clr_v_i;

   // Retiring is only legal for entries that have already been read.
   assign deq_ok = deq_v_i & (cptr_q != rptr_q);

   assign unretired_cnt_o = wptr_q - cptr_q;

`ifdef BP_FE_QUEUE_REPLAY_BYPASS_EN
   logic bypass_v;

   // Nothing unread: present the incoming packet directly this cycle.
   assign bypass_v = (rptr_q == wptr_q) & v_i & ~clr_v_i;

   assign v_o    = unread_v | bypass_v;
   assign data_o = bypass_v ? data_i : mem_q[raddr];
`else
   assign v_o    = unread_v;
   assign data_o = mem_q[raddr];
`endif

   // Next-state pointers, resolving clr > roll > {yumi, deq, enq}.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cptr_d = cptr_q;
      if (clr_v_i) begin
         wptr_d = wptr_q;
         rptr_d = wptr_q;
         cptr_d = wptr_q;
      end else begin
         wptr_d = wptr_q + ptr_t'(enq_v);
         cptr_d = cptr_q + ptr_t'(deq_ok);
         if (roll_v_i) begin
            // Rewind lands on the post-deq commit point; yumi is ignored.
            rptr_d = cptr_q + ptr_t'(deq_ok);
         end else begin
            rptr_d = rptr_q + ptr_t'(yumi_i);
         end
      end
   end

   // Pointer registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cptr_q <= cptr_d;
      end
   end

   // Payload storage; contents survive reset and clr, only pointers move.
   always_ff @(posedge clk_i) begin
      if (!reset_i && enq_v) begin
         mem_q[waddr] <= data_i;
      end
   end

`ifndef SYNTHESIS
   // Protocol checks on the producer and consumer handshakes.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(v_i && !ready_o))
            else $error("bp_fe_queue_replay_fifo: enqueue while not ready");
         assert (!(yumi_i && !v_o))
            else $error("bp_fe_queue_replay_fifo: yumi without valid data");
         assert (!(deq_v_i && !clr_v_i && (cptr_q == rptr_q)))
            else $error("bp_fe_queue_replay_fifo: deq of an unread entry");
      end
   end
`endif

endmodule

// File: tb/tb_bp_fe_queue_replay_fifo.sv
// Scoreboard bench for bp_fe_queue_replay_fifo (els_p=4, width_p=8).
// Stimulus pushes the expected payload whenever it asserts yumi; a monitor
// pops and compares on every consumed beat. Direct checks cover status.
module tb_bp_fe_queue_replay_fifo;

   localparam int unsigned W = 8;
   localparam int unsigned N = 4;

   logic         clk;
   logic         reset;
   logic         clr_v, deq_v, roll_v;
   logic [W-1:0] data_in;
   logic         v_in;
   logic         ready;
   logic [W-1:0] data_out;
   logic         v_out;
   logic         yumi;
   logic [2:0]   cnt;

   int vectors     = 0;
   int miscompares = 0;

   logic [W-1:0] exp_q [$];

   bp_fe_queue_replay_fifo #(
      .width_p (W),
      .els_p   (N)
   ) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .clr_v_i         (clr_v),
      .deq_v_i         (deq_v),
      .roll_v_i        (roll_v),
      .data_i          (data_in),
      .v_i             (v_in),
      .ready_o         (ready),
      .data_o          (data_out),
      .v_o             (v_out),
      .yumi_i          (yumi),
      .unretired_cnt_o (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every consumed beat must match the oldest expected payload.
   always @(negedge clk) begin
      if (!reset && v_out && yumi) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL consume: got %02h with no expected entry", data_out);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (data_out !== e) begin
               miscompares++;
               $display("FAIL consume: got %02h expected %02h", data_out, e);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      clr_v   = 1'b0;
      deq_v   = 1'b0;
      roll_v  = 1'b0;
      v_in    = 1'b0;
      data_in = '0;
      yumi    = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic enq(input logic [W-1:0] d);
      v_in    = 1'b1;
      data_in = d;
      tick();
   endtask

   task automatic rd(input logic [W-1:0] d, input logic with_deq);
      exp_q.push_back(d);
      yumi  = 1'b1;
      deq_v = with_deq;
      tick();
   endtask

   task automatic deq();
      deq_v = 1'b1;
      tick();
   endtask

   initial begin
      int cycles;
      int enq_n, rd_n, ret_n;
      idle();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset v_o", 32'(v_out), 32'd0);
      chk("reset ready_o", 32'(ready), 32'd1);
      chk("reset cnt", 32'(cnt), 32'd0);

      // Basic order
      v_in    = 1'b1;
      data_in = 8'h11;
      #1;
`ifdef BP_FE_QUEUE_REPLAY_BYPASS_EN
      chk("enq same-cycle v_o", 32'(v_out), 32'd1);
`else
      chk("enq same-cycle v_o", 32'(v_out), 32'd0);
`endif
      tick();
      chk("basic v_o", 32'(v_out), 32'd1);
      chk("basic head", 32'(data_out), 32'h11);
      chk("basic cnt1", 32'(cnt), 32'd1);
      enq(8'h22);
      enq(8'h33);
      chk("basic cnt3", 32'(cnt), 32'd3);
      chk("basic ready", 32'(ready), 32'd1);
      rd(8'h11, 1'b0);
      rd(8'h22, 1'b1);
      rd(8'h33, 1'b1);
      chk("basic drained v_o", 32'(v_out), 32'd0);
      chk("basic cnt after 2 deq", 32'(cnt), 32'd1);
      deq();
      chk("basic cnt0", 32'(cnt), 32'd0);

      // Roll
      enq(8'hA0);
      enq(8'hA1);
      enq(8'hA2);
      enq(8'hA3);
      chk("roll full ready", 32'(ready), 32'd0);
      chk("roll full cnt", 32'(cnt), 32'd4);
      rd(8'hA0, 1'b0);
      rd(8'hA1, 1'b0);
      rd(8'hA2, 1'b0);
      deq_v = 1'b1;
      #1;
      chk("deq-cycle ready", 32'(ready), 32'd0);
      tick();
      chk("post-deq ready", 32'(ready), 32'd1);
      chk("post-deq cnt", 32'(cnt), 32'd3);
      roll_v = 1'b1;
      tick();
      chk("roll v_o", 32'(v_out), 32'd1);
      chk("roll head", 32'(data_out), 32'hA1);
      chk("roll cnt", 32'(cnt), 32'd3);
      rd(8'hA1, 1'b0);
      rd(8'hA2, 1'b0);
      rd(8'hA3, 1'b0);
      chk("roll drained v_o", 32'(v_out), 32'd0);
      deq();
      deq();
      deq();
      chk("roll cnt0", 32'(cnt), 32'd0);

      // Clr vs enqueue
      enq(8'hC1);
      enq(8'hC2);
      rd(8'hC1, 1'b0);
      clr_v   = 1'b1;
      v_in    = 1'b1;
      data_in = 8'h55;
      tick();
      chk("clr v_o", 32'(v_out), 32'd0);
      chk("clr cnt", 32'(cnt), 32'd0);
      chk("clr ready", 32'(ready), 32'd1);
      tick();
      tick();
      chk("clr v_o later", 32'(v_out), 32'd0);
      enq(8'h66);
      chk("post-clr head", 32'(data_out), 32'h66);
      rd(8'h66, 1'b0);
      deq();
      chk("post-clr cnt0", 32'(cnt), 32'd0);

      // Roll + deq same cycle
      enq(8'h01);
      enq(8'h02);
      enq(8'h03);
      rd(8'h01, 1'b0);
      rd(8'h02, 1'b0);
      rd(8'h03, 1'b0);
      roll_v = 1'b1;
      deq_v  = 1'b1;
      tick();
      chk("roll+deq v_o", 32'(v_out), 32'd1);
      chk("roll+deq head", 32'(data_out), 32'h02);
      chk("roll+deq cnt", 32'(cnt), 32'd2);
      rd(8'h02, 1'b0);
      rd(8'h03, 1'b0);
      deq();
      deq();
      chk("roll+deq cnt0", 32'(cnt), 32'd0);

      // Wrap: pipelined enqueue/yumi/deq of 0..9
      enq_n  = 0;
      rd_n   = 0;
      ret_n  = 0;
      cycles = 0;
      while (ret_n < 10 && cycles < 30) begin
         chk("wrap ready", 32'(ready), 32'((enq_n - ret_n) < int'(N)));
         chk("wrap v_o", 32'(v_out), 32'(rd_n < enq_n));
         if (enq_n < 10 && (enq_n - ret_n) < int'(N)) begin
            v_in    = 1'b1;
            data_in = W'(enq_n);
         end
         if (rd_n < enq_n) begin
            yumi = 1'b1;
            exp_q.push_back(W'(rd_n));
         end
         if (ret_n < rd_n) deq_v = 1'b1;
         if (v_in) enq_n++;
         if (yumi) rd_n++;
         if (deq_v) ret_n++;
         tick();
         cycles++;
      end
      chk("wrap cycles", 32'(cycles), 32'd12);
      chk("wrap cnt0", 32'(cnt), 32'd0);

      // Reset mid-operation overrides a same-cycle enqueue
      enq(8'hD1);
      enq(8'hD2);
      reset   = 1'b1;
      v_in    = 1'b1;
      data_in = 8'hEE;
      tick();
      reset = 1'b0;
      chk("mid-reset v_o", 32'(v_out), 32'd0);
      chk("mid-reset cnt", 32'(cnt), 32'd0);
      chk("mid-reset ready", 32'(ready), 32'd1);
      enq(8'h99);
      chk("post-reset head", 32'(data_out), 32'h99);
      rd(8'h99, 1'b0);
      deq();

`ifdef BP_FE_QUEUE_REPLAY_BYPASS_EN
      // Same-cycle bypass, then replay from the array
      v_in    = 1'b1;
      data_in = 8'h7E;
      yumi    = 1'b1;
      exp_q.push_back(8'h7E);
      #1;
      chk("bypass v_o", 32'(v_out), 32'd1);
      chk("bypass data", 32'(data_out), 32'h7E);
      tick();
      chk("bypass consumed v_o", 32'(v_out), 32'd0);
      roll_v = 1'b1;
      tick();
      chk("bypass roll v_o", 32'(v_out), 32'd1);
      chk("bypass roll data", 32'(data_out), 32'h7E);
      rd(8'h7E, 1'b0);
      deq();
`endif

      chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
      chk("final cnt", 32'(cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
